wb_stage_seq: RTL and testbench
===============================

# wb_stage_seq

Registered, parametrised write-back stage for the RISC-V pipeline. Accepts retiring instructions from the memory stage through a valid/ready handshake, and waits for late load data when required. Formats load data by size, sign and byte offset, then drives a one-cycle register-file write strobe. Also counts retired instructions and flags load faults, replacing the purely combinational ALU/memory select used so far.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64 only.
- CNT_W, 32, width of the retire counter.
- OFF_W, derived = log2(XLEN/8), width of the byte-offset input.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset. Single clock domain.
- i_valid  in  1  memory stage presents an instruction.
- o_ready  out  1  stage can accept; transfer occurs when i_valid && o_ready.
- i_flush  in  1  synchronous kill of any pending load and of this cycle's transfer.
- i_op_type  in  2  00 ALU result, 01 load, 10/11 no write-back (store/branch).
- i_rd_num  in  5  destination register.
- i_alu_out  in  XLEN  ALU result.
- i_funct3  in  3  load size/sign encoding.
- i_addr_lo  in  OFF_W  low bits of the load address.
- i_mem_valid  in  1  load data valid this cycle.
- i_mem_out  in  XLEN  raw aligned memory word.
- rd_we  out  1  register-file write strobe, 1 cycle.
- rd_num  out  5  write-back register.
- rd  out  XLEN  write-back data.
- o_load_fault  out  1  1-cycle pulse: misaligned or illegal load.
- o_retired  out  CNT_W  retired-instruction count.

## Operation
- States: IDLE, WAIT_MEM.
- IDLE:
  - o_ready=1.
  - On transfer with ALU op: rd=i_alu_out, rd_num=i_rd_num, rd_we=1 next cycle.
  - On transfer with op 10/11: no write; retire counted.
  - On transfer with load and i_mem_valid=1 in the same cycle: write the formatted data next cycle.
  - On transfer with load and i_mem_valid=0: capture rd_num, funct3 and addr_lo; go to WAIT_MEM.
- WAIT_MEM:
  - o_ready=0.
  - On i_mem_valid: write the formatted data next cycle; go to IDLE.
  - i_mem_valid in IDLE without a load transfer is ignored.
- Load formatting: extract byte/half/word at byte offset addr_lo, then sign- or zero-extend to XLEN.
  - funct3 000 LB, 100 LBU, 001 LH, 101 LHU, 010 LW (sign-extended).
  - 110 LWU and 011 LD are legal only when XLEN=64.
- Load fault: raised for a misaligned access (half with addr_lo[0]=1, word with addr_lo[1:0]≠0, double with addr_lo≠0) or an illegal funct3.
  - Checked at acceptance.
  - On fault: o_load_fault pulses next cycle, rd_we=0, no WAIT_MEM entry, instruction not counted.
- rd_num=0: rd_we is forced 0; the instruction is still retired.
- Retire counter: +1 on each write-back or no-write retire; wraps from 2^CNT_W−1 to 0.
- Flush:
  - Takes priority over everything.
  - In WAIT_MEM, returns to IDLE without writing; a same-cycle i_mem_valid is discarded.
  - In IDLE, the transfer that cycle is dropped.
  - Nothing is retired.

## Timing
- Reset state: IDLE; rd_we=0, rd_num=0, rd=0, o_load_fault=0, o_retired=0; o_ready=1 once reset deasserts.
- Latency:
  - ALU op or same-cycle load: transfer at edge N → rd_we high during cycle N+1.
  - Late load: i_mem_valid at edge M → rd_we during cycle M+1.
- o_retired increments on the same edge at which rd_we rises.
- rd_we and o_load_fault are high for exactly one cycle per event.
- rd/rd_num hold their last value when rd_we=0.
- Back-to-back ALU ops sustain 1 instruction per cycle.
- o_ready is combinational from state only; it has no path from i_valid.
- Reset asserted mid-WAIT_MEM clears immediately to IDLE; no write occurs.

## Test plan
- Reset, then three back-to-back ALU ops (x1=5, x2=0xFFFFFFFF, x3=7) → rd_we high 3 consecutive cycles with those values; o_retired=3.
- Load LB, addr_lo=3, mem word 0x80FF_1234, same-cycle valid → rd=0xFFFF_FF80, rd_we 1 cycle later. Repeat as LBU → 0x0000_0080.
- Load LH with mem_valid 4 cycles late, mem 0x8001_0000, addr_lo=2 → o_ready=0 for 4 cycles; then rd=0xFFFF_8001.
- LW with addr_lo=1 → o_load_fault pulse, rd_we=0, o_retired unchanged. ALU op to x0 → rd_we=0, o_retired+1.
- Pending load, assert i_flush together with i_mem_valid → no write; IDLE next cycle. Separately, assert reset mid-wait → all outputs 0.
- CNT_W=4: retire 17 instructions → o_retired=1. XLEN=64: LWU of 0xFFFF_FFFF → rd=0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/wb_stage_seq.sv
// Registered RISC-V write-back stage: valid/ready intake, late-load wait,
// load formatting, single-cycle register-file write strobe and retire counter.
module wb_stage_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic [1:0]       i_op_type,
    input  logic [4:0]       i_rd_num,
    input  logic [XLEN-1:0]  i_alu_out,
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_addr_lo,
    input  logic             i_mem_valid,
    input  logic [XLEN-1:0]  i_mem_out,
    output logic             rd_we,
    output logic [4:0]       rd_num,
    output logic [XLEN-1:0]  rd,
    output logic             o_load_fault,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t           state, state_nx;
    logic [4:0]       p_rd_num;
    logic [2:0]       p_funct3;
    logic [OFF_W-1:0] p_addr_lo;

    logic             do_write, do_retire, fault_nx, capture, acc_fault;
    logic [4:0]       wr_num;
    logic [XLEN-1:0]  wr_data;

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [XLEN-1:0] word);
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        w  = sh[31:0];
        // signed-source size casts give the sign extension
        case (f3)
            3'b000:  fmt_load = XLEN'(b);
            3'b100:  fmt_load = XLEN'(sh[7:0]);
            3'b001:  fmt_load = XLEN'(h);
            3'b101:  fmt_load = XLEN'(sh[15:0]);
            3'b010:  fmt_load = XLEN'(w);
            3'b110:  fmt_load = XLEN'(sh[31:0]);
            default: fmt_load = sh;
        endcase
    endfunction

    function automatic logic load_bad(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        logic illegal, misaligned;
        illegal = (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            2'b11:   misaligned = (off != '0);
            default: misaligned = 1'b0;
        endcase
        load_bad = illegal || misaligned;
    endfunction

    assign o_ready   = (state == IDLE);
    assign acc_fault = load_bad(i_funct3, i_addr_lo);

    always_comb begin
        state_nx  = state;
        do_write  = 1'b0;
        do_retire = 1'b0;
        fault_nx  = 1'b0;
        capture   = 1'b0;
        wr_num    = i_rd_num;
        wr_data   = i_alu_out;
        if (i_flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        case (i_op_type)
                            2'b00: begin
                                do_write  = 1'b1;
                                do_retire = 1'b1;
                            end
                            2'b01: begin
                                if (acc_fault) begin
                                    fault_nx = 1'b1;
                                end else if (i_mem_valid) begin
                                    do_write  = 1'b1;
                                    do_retire = 1'b1;
                                    wr_data   = fmt_load(i_funct3, i_addr_lo, i_mem_out);
                                end else begin
                                    capture  = 1'b1;
                                    state_nx = WAIT_MEM;
                                end
                            end
                            default: do_retire = 1'b1;
                        endcase
                    end
                end
                WAIT_MEM: begin
                    if (i_mem_valid) begin
                        do_write  = 1'b1;
                        do_retire = 1'b1;
                        wr_num    = p_rd_num;
                        wr_data   = fmt_load(p_funct3, p_addr_lo, i_mem_out);
                        state_nx  = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rd_we        <= 1'b0;
            rd_num       <= '0;
            rd           <= '0;
            o_load_fault <= 1'b0;
            o_retired    <= '0;
            p_rd_num     <= '0;
            p_funct3     <= '0;
            p_addr_lo    <= '0;
        end else begin
            state        <= state_nx;
            o_load_fault <= fault_nx;
            rd_we        <= do_write && (wr_num != 5'd0);
            // x0 writes retire but leave rd/rd_num holding their last value
            if (do_write && (wr_num != 5'd0)) begin
                rd     <= wr_data;
                rd_num <= wr_num;
            end
            if (do_retire) o_retired <= o_retired + CNT_W'(1);
            if (capture) begin
                p_rd_num  <= i_rd_num;
                p_funct3  <= i_funct3;
                p_addr_lo <= i_addr_lo;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Bench for wb_stage_seq: a 32-bit and a 64-bit (4-bit counter) instance share
// one stimulus stream and are each checked against a behavioural model.
module tb_wb_stage_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid, flush, mval;
    logic [1:0]  op;
    logic [4:0]  rdn;
    logic [63:0] alu, mem;
    logic [2:0]  f3;
    logic [2:0]  addr;

    logic        ready32, we32, flt32;
    logic [4:0]  num32;
    logic [31:0] rd32, ret32;
    logic        ready64, we64, flt64;
    logic [4:0]  num64;
    logic [63:0] rd64;
    logic [3:0]  ret64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_seq #(.XLEN(32), .CNT_W(32)) dut32 (
        .clk(clk), .reset(reset), .i_valid(valid), .o_ready(ready32), .i_flush(flush),
        .i_op_type(op), .i_rd_num(rdn), .i_alu_out(alu[31:0]), .i_funct3(f3),
        .i_addr_lo(addr[1:0]), .i_mem_valid(mval), .i_mem_out(mem[31:0]),
        .rd_we(we32), .rd_num(num32), .rd(rd32), .o_load_fault(flt32), .o_retired(ret32)
    );

    wb_stage_seq #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .reset(reset), .i_valid(valid), .o_ready(ready64), .i_flush(flush),
        .i_op_type(op), .i_rd_num(rdn), .i_alu_out(alu), .i_funct3(f3),
        .i_addr_lo(addr), .i_mem_valid(mval), .i_mem_out(mem),
        .rd_we(we64), .rd_num(num64), .rd(rd64), .o_load_fault(flt64), .o_retired(ret64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: XLEN=32, 1: XLEN=64) ----------------
    bit          pend[2];
    logic [4:0]  prd[2];
    logic [2:0]  pf3[2];
    int          poff[2];
    bit          e_we[2], e_flt[2];
    logic [4:0]  e_num[2];
    logic [63:0] e_rd[2], e_ret[2];

    function automatic logic [63:0] xmask(int k, logic [63:0] v);
        return (k == 1) ? v : (v & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [63:0] sext(logic [63:0] v, int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        v = v & m;
        if (v[n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [63:0] fmt_m(int k, logic [2:0] fn, int off, logic [63:0] word);
        logic [63:0] w, r;
        w = xmask(k, word) >> (8 * off);
        case (fn)
            3'd0:    r = sext(w, 8);
            3'd4:    r = w & 64'hFF;
            3'd1:    r = sext(w, 16);
            3'd5:    r = w & 64'hFFFF;
            3'd2:    r = sext(w, 32);
            3'd6:    r = w & 64'hFFFF_FFFF;
            default: r = w;
        endcase
        return xmask(k, r);
    endfunction

    function automatic bit load_ok(int k, logic [2:0] fn, int off);
        int size;
        if (fn == 3'd7) return 0;
        if (k == 0 && (fn == 3'd3 || fn == 3'd6)) return 0;
        size = 1 << fn[1:0];
        return (off % size) == 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; prd[k] = '0; pf3[k] = '0; poff[k] = 0;
            e_we[k] = 0; e_flt[k] = 0; e_num[k] = '0; e_rd[k] = '0; e_ret[k] = '0;
        end
    endtask

    task automatic model_wb(int k, logic [4:0] n, logic [63:0] v);
        e_ret[k] = (e_ret[k] + 64'd1) & ((k == 1) ? 64'hF : 64'hFFFF_FFFF);
        if (n != 5'd0) begin
            e_we[k] = 1; e_num[k] = n; e_rd[k] = v;
        end
    endtask

    task automatic model_step(int k);
        int off;
        off = (k == 1) ? int'(addr) : int'(addr[1:0]);
        e_we[k] = 0;
        e_flt[k] = 0;
        if (flush) begin
            pend[k] = 0;
        end else if (pend[k]) begin
            if (mval) begin
                model_wb(k, prd[k], fmt_m(k, pf3[k], poff[k], mem));
                pend[k] = 0;
            end
        end else if (valid) begin
            case (op)
                2'd0: model_wb(k, rdn, xmask(k, alu));
                2'd1: begin
                    if (!load_ok(k, f3, off)) e_flt[k] = 1;
                    else if (mval) model_wb(k, rdn, fmt_m(k, f3, off, mem));
                    else begin
                        pend[k] = 1; prd[k] = rdn; pf3[k] = f3; poff[k] = off;
                    end
                end
                default: model_wb(k, 5'd0, 64'd0);
            endcase
        end
    endtask

    always @(posedge reset) model_clear();

    always @(posedge clk) begin
        if (reset) model_clear();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        chk("ready32", {63'd0, ready32}, {63'd0, !pend[0]});
        chk("we32", {63'd0, we32}, {63'd0, e_we[0]});
        chk("num32", {59'd0, num32}, {59'd0, e_num[0]});
        chk("rd32", {32'd0, rd32}, e_rd[0]);
        chk("flt32", {63'd0, flt32}, {63'd0, e_flt[0]});
        chk("ret32", {32'd0, ret32}, e_ret[0]);
        chk("ready64", {63'd0, ready64}, {63'd0, !pend[1]});
        chk("we64", {63'd0, we64}, {63'd0, e_we[1]});
        chk("num64", {59'd0, num64}, {59'd0, e_num[1]});
        chk("rd64", rd64, e_rd[1]);
        chk("flt64", {63'd0, flt64}, {63'd0, e_flt[1]});
        chk("ret64", {60'd0, ret64}, e_ret[1]);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic [1:0] o, input logic [4:0] n,
                          input logic [63:0] a, input logic [2:0] fn, input logic [2:0] ad,
                          input logic mv, input logic [63:0] m, input logic fl);
        valid = v; op = o; rdn = n; alu = a; f3 = fn; addr = ad; mval = mv; mem = m; flush = fl;
    endtask

    task automatic idle();
        set_in(0, 2'd0, 5'd0, 64'd0, 3'd0, 3'd0, 0, 64'd0, 0);
    endtask

    task automatic cycle(input logic v, input logic [1:0] o, input logic [4:0] n,
                         input logic [63:0] a, input logic [2:0] fn, input logic [2:0] ad,
                         input logic mv, input logic [63:0] m, input logic fl);
        @(negedge clk);
        set_in(v, o, n, a, fn, ad, mv, m, fl);
        @(posedge clk);
        #2;
    endtask

    logic [31:0] ret_before;

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_we", {63'd0, we32}, 64'd0);
        chk("rst_rd", {32'd0, rd32}, 64'd0);
        chk("rst_num", {59'd0, num32}, 64'd0);
        chk("rst_ret", {32'd0, ret32}, 64'd0);
        chk("rst_flt", {63'd0, flt32}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_ready", {63'd0, ready32}, 64'd1);

        cycle(1, 2'd0, 5'd1, 64'd5, 3'd0, 3'd0, 0, 64'd0, 0);
        chk("alu1_we", {63'd0, we32}, 64'd1);
        chk("alu1_rd", {32'd0, rd32}, 64'd5);
        cycle(1, 2'd0, 5'd2, 64'hFFFF_FFFF, 3'd0, 3'd0, 0, 64'd0, 0);
        chk("alu2_we", {63'd0, we32}, 64'd1);
        chk("alu2_rd", {32'd0, rd32}, 64'hFFFF_FFFF);
        cycle(1, 2'd0, 5'd3, 64'd7, 3'd0, 3'd0, 0, 64'd0, 0);
        chk("alu3_we", {63'd0, we32}, 64'd1);
        chk("alu3_rd", {32'd0, rd32}, 64'd7);
        chk("alu3_num", {59'd0, num32}, 64'd3);
        chk("alu3_ret", {32'd0, ret32}, 64'd3);

        cycle(1, 2'd1, 5'd5, 64'd0, 3'd0, 3'd3, 1, 64'h80FF_1234, 0);
        chk("lb_rd", {32'd0, rd32}, 64'hFFFF_FF80);
        chk("lb64_rd", rd64, 64'hFFFF_FFFF_FFFF_FF80);
        cycle(1, 2'd1, 5'd5, 64'd0, 3'd4, 3'd3, 1, 64'h80FF_1234, 0);
        chk("lbu_rd", {32'd0, rd32}, 64'h0000_0080);

        cycle(1, 2'd1, 5'd6, 64'd0, 3'd1, 3'd2, 0, 64'd0, 0);
        chk("lh_wait0", {63'd0, ready32}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            cycle(0, 2'd0, 5'd0, 64'd0, 3'd0, 3'd0, 0, 64'd0, 0);
            chk("lh_wait", {63'd0, ready32}, 64'd0);
        end
        cycle(0, 2'd0, 5'd0, 64'd0, 3'd0, 3'd0, 1, 64'h8001_0000, 0);
        chk("lh_we", {63'd0, we32}, 64'd1);
        chk("lh_rd", {32'd0, rd32}, 64'hFFFF_8001);
        chk("lh_ready", {63'd0, ready32}, 64'd1);

        ret_before = ret32;
        cycle(1, 2'd1, 5'd7, 64'd0, 3'd2, 3'd1, 1, 64'h1234_5678, 0);
        chk("lw_fault", {63'd0, flt32}, 64'd1);
        chk("lw_we", {63'd0, we32}, 64'd0);
        chk("lw_ret", {32'd0, ret32}, {32'd0, ret_before});
        cycle(1, 2'd0, 5'd0, 64'd99, 3'd0, 3'd0, 0, 64'd0, 0);
        chk("x0_we", {63'd0, we32}, 64'd0);
        chk("x0_flt", {63'd0, flt32}, 64'd0);
        chk("x0_ret", {32'd0, ret32}, {32'd0, ret_before + 32'd1});

        cycle(1, 2'd1, 5'd4, 64'd0, 3'd2, 3'd0, 0, 64'd0, 0);
        cycle(0, 2'd0, 5'd0, 64'd0, 3'd0, 3'd0, 1, 64'hDEAD_BEEF, 1);
        chk("flush_we", {63'd0, we32}, 64'd0);
        chk("flush_ready", {63'd0, ready32}, 64'd1);

        cycle(1, 2'd1, 5'd4, 64'd0, 3'd2, 3'd0, 0, 64'd0, 0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("arst_ready", {63'd0, ready32}, 64'd1);
        chk("arst_rd", {32'd0, rd32}, 64'd0);
        chk("arst_num", {59'd0, num32}, 64'd0);
        chk("arst_ret", {32'd0, ret32}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) cycle(1, 2'd2, 5'd0, 64'd0, 3'd0, 3'd0, 0, 64'd0, 0);
        chk("wrap_ret64", {60'd0, ret64}, 64'd1);
        chk("wrap_ret32", {32'd0, ret32}, 64'd17);

        cycle(1, 2'd1, 5'd9, 64'd0, 3'd6, 3'd0, 1, 64'hFFFF_FFFF, 0);
        chk("lwu64_rd", rd64, 64'h0000_0000_FFFF_FFFF);
        chk("lwu32_fault", {63'd0, flt32}, 64'd1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            set_in(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                   2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   {$urandom, $urandom},
                   3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
                   {$urandom, $urandom},
                   ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        idle();
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
